bit_serial_sub_8: RTL

- Sequential 8-bit subtractor, the inverse operation to the team's parallel ripple-carry adder.
- Computes d = a - b - b_in one bit per clock, LSB first. The borrow ripples through time in one flip-flop instead of through a chain of cells.
- Used in the datapath where area matters more than latency. It is also the subtract engine for later shift-subtract divider work.
- Start/busy/done handshake, with borrow-out, signed-overflow and zero flags.

---
 rtl/bit_serial_sub_8_pkg.sv | 16 +
 rtl/bit_serial_sub_8_full_subtractor.sv | 15 +
 rtl/bit_serial_sub_8.sv | 106 ++++++++++
 3 files changed

// File: rtl/bit_serial_sub_8_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package bit_serial_sub_8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_sub_8_full_subtractor.sv
// One-bit full subtractor: diff = x - y - bin, with borrow out.
module full_subtractor_1_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/bit_serial_sub_8.sv
// Sequential subtractor computing d = a - b - b_in one bit per clock, LSB first,
// with a start/busy/done handshake and borrow/overflow/zero flags.
module bit_serial_sub_8
  import bit_serial_sub_8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             v,
  output logic             z
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  sa;
  logic [WIDTH-1:0]  sb;
  logic [WIDTH-1:0]  sr;
  logic [WIDTH-1:0]  res_next;
  logic              br;
  logic              br_next;
  logic              dbit;
  logic [CW-1:0]     cnt;

  full_subtractor_1_bit u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .diff (dbit),
    .bout (br_next)
  );

  always_comb begin
    state_next = state;
    res_next   = {dbit, sr[WIDTH-1:1]};
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      d     <= '0;
      b_out <= 1'b0;
      v     <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= b_in;
            cnt   <= '0;
            sr    <= '0;
            d     <= '0;
            b_out <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= res_next;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          // On the MSB step br is the borrow into the MSB, so br ^ br_next is signed overflow.
          if (cnt == LAST) begin
            d     <= res_next;
            b_out <= br_next;
            v     <= br ^ br_next;
            z     <= (res_next == '0);
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
